// File: rtl/adc_sched_pkg.sv
// ADC readout scheduler shared types and constants.
// Also holds the SPI register map seen by the SPI slave.
package adc_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int DROP_CNT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PENDING,
    PUBLISH
  } state_t;

  localparam logic [7:0] SPI_ADDR_SNAP0  = 8'h00;
  localparam logic [7:0] SPI_ADDR_SNAP1  = 8'h01;
  localparam logic [7:0] SPI_ADDR_SNAP2  = 8'h02;
  localparam logic [7:0] SPI_ADDR_SNAP3  = 8'h03;
  localparam logic [7:0] SPI_ADDR_VALID  = 8'h04;
  localparam logic [7:0] SPI_ADDR_CNT    = 8'h05;
  localparam logic [7:0] SPI_ADDR_STATUS = 8'h06;
  localparam logic [7:0] SPI_ADDR_DROP   = 8'h07;

  function automatic logic [2:0] popcnt(
    input logic [NUM_CH-1:0] v
  );
    popcnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      popcnt = popcnt + 3'(v[i]);
  endfunction

endpackage

// File: rtl/adc_stage_bank.sv
// Per-channel staging registers, got flags and overwrite detection.
// restart marks the publish cycle: new pulses open the next frame.
module adc_stage_bank
  import adc_sched_pkg::*;
#(
  parameter logic [NUM_CH-1:0] CH_MASK = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     accept,
  input  logic                     restart,
  input  logic [NUM_CH-1:0][15:0]  adc_in,
  input  logic [NUM_CH-1:0]        valid,
  output logic [NUM_CH-1:0][15:0]  stage,
  output logic [NUM_CH-1:0]        got,
  output logic [NUM_CH-1:0]        got_next,
  output logic [NUM_CH-1:0]        drop
);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] base;

  assign hit      = valid & CH_MASK & {NUM_CH{accept}};
  assign base     = restart ? '0 : got;
  assign got_next = base | hit;
  assign drop     = hit & base;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
      got   <= '0;
    end else begin
      got <= clr ? '0 : got_next;
      for (int i = 0; i < NUM_CH; i++)
        if (hit[i]) stage[i] <= adc_in[i];
    end
  end

endmodule

// File: rtl/adc_readout_scheduler.sv
// Frame scheduler: collects one sample per channel and publishes
// a coherent snapshot only while the SPI slave is idle.
module adc_readout_scheduler
  import adc_sched_pkg::*;
#(
  parameter logic [NUM_CH-1:0] CH_MASK = 4'hF,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TMR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] adc_ch0,
  input  logic [15:0] adc_ch1,
  input  logic [15:0] adc_ch2,
  input  logic [15:0] adc_ch3,
  input  logic [3:0]  adc_data_valid,
  input  logic        spi_busy,
  input  logic        clear_status,
  output logic [15:0] snap_ch0,
  output logic [15:0] snap_ch1,
  output logic [15:0] snap_ch2,
  output logic [15:0] snap_ch3,
  output logic [3:0]  snap_valid,
  output logic [31:0] sample_cnt,
  output logic        drdy,
  output logic        overrun,
  output logic [7:0]  drop_cnt,
  output logic        partial
);

  state_t state;
  logic [TMR_W-1:0] timer;
  logic partial_pend;
  logic spi_busy_q;
  logic spi_rise;
  logic accept;
  logic restart;
  logic full;
  logic tmr_hit;
  logic [8:0] drop_sum;
  logic [7:0] drop_sat;
  logic [NUM_CH-1:0][15:0] adc_in;
  logic [NUM_CH-1:0][15:0] stage;
  logic [NUM_CH-1:0] got;
  logic [NUM_CH-1:0] got_next;
  logic [NUM_CH-1:0] drop;

  assign adc_in   = {adc_ch3, adc_ch2, adc_ch1, adc_ch0};
  assign accept   = enable && (state != IDLE);
  assign restart  = (state == PUBLISH);
  assign full     = (got_next & CH_MASK) == CH_MASK;
  assign tmr_hit  = timer == TMR_W'(TIMEOUT_CYCLES - 1);
  assign spi_rise = spi_busy && !spi_busy_q;
  assign drop_sum = {1'b0, drop_cnt} + 9'(popcnt(drop));
  assign drop_sat = (drop_sum > 9'(DROP_CNT_MAX))
                  ? 8'(DROP_CNT_MAX) : drop_sum[7:0];

  adc_stage_bank #(
    .CH_MASK (CH_MASK)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .clr      (!enable),
    .accept   (accept),
    .restart  (restart),
    .adc_in   (adc_in),
    .valid    (adc_data_valid),
    .stage    (stage),
    .got      (got),
    .got_next (got_next),
    .drop     (drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      partial_pend <= 1'b0;
      spi_busy_q   <= 1'b0;
      snap_ch0     <= '0;
      snap_ch1     <= '0;
      snap_ch2     <= '0;
      snap_ch3     <= '0;
      snap_valid   <= '0;
      sample_cnt   <= '0;
      drdy         <= 1'b0;
      overrun      <= 1'b0;
      drop_cnt     <= '0;
      partial      <= 1'b0;
    end else begin
      spi_busy_q <= spi_busy;
      if (spi_rise) drdy <= 1'b0;
      // a same-cycle drop or overrun beats clear_status
      if (|drop) drop_cnt <= drop_sat;
      else if (clear_status) drop_cnt <= '0;
      if (clear_status) overrun <= 1'b0;
      if (!enable) begin
        state        <= IDLE;
        timer        <= '0;
        partial_pend <= 1'b0;
        drdy         <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= COLLECT;
            timer <= '0;
          end
          COLLECT: begin
            if (full) begin
              state <= PENDING;
            end else if (tmr_hit) begin
              timer <= '0;
              if (|got_next) begin
                state        <= PENDING;
                partial_pend <= 1'b1;
              end
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          PENDING: begin
            if (!spi_busy) state <= PUBLISH;
          end
          PUBLISH: begin
            snap_ch0     <= stage[0];
            snap_ch1     <= stage[1];
            snap_ch2     <= stage[2];
            snap_ch3     <= stage[3];
            snap_valid   <= got & CH_MASK;
            partial      <= partial_pend;
            sample_cnt   <= sample_cnt + 32'd1;
            drdy         <= 1'b1;
            if (drdy) overrun <= 1'b1;
            partial_pend <= 1'b0;
            timer        <= '0;
            state        <= COLLECT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_readout_scheduler.sv
// Scoreboard bench for adc_readout_scheduler.
// Expected frames queue on stimulus, popped on each publish.
module tb_adc_readout_scheduler;
  import adc_sched_pkg::*;

  typedef struct {
    logic [3:0][15:0] ch;
    logic [3:0]       v;
    logic             p;
    logic [31:0]      cnt;
  } frame_t;

  logic clk = 0;
  logic rst = 1;
  logic enable = 0;
  logic [15:0] adc [4];
  logic [3:0] vld = 0;
  logic spi_busy = 0;
  logic clear_status = 0;
  logic [15:0] snap_ch0, snap_ch1, snap_ch2, snap_ch3;
  logic [3:0] snap_valid;
  logic [31:0] sample_cnt;
  logic drdy, overrun, partial;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad = 0;
  frame_t exp_q[$];
  logic [3:0][15:0] mstage = '0;
  logic [31:0] cnt_model = 0;
  logic [31:0] prev_cnt = 0;
  logic [15:0] held0;
  bit mon_on = 0;

  always #10 clk = ~clk;

  adc_readout_scheduler #(
    .CH_MASK        (4'hF),
    .TIMEOUT_CYCLES (100),
    .TMR_W          (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .adc_ch0        (adc[0]),
    .adc_ch1        (adc[1]),
    .adc_ch2        (adc[2]),
    .adc_ch3        (adc[3]),
    .adc_data_valid (vld),
    .spi_busy       (spi_busy),
    .clear_status   (clear_status),
    .snap_ch0       (snap_ch0),
    .snap_ch1       (snap_ch1),
    .snap_ch2       (snap_ch2),
    .snap_ch3       (snap_ch3),
    .snap_valid     (snap_valid),
    .sample_cnt     (sample_cnt),
    .drdy           (drdy),
    .overrun        (overrun),
    .drop_cnt       (drop_cnt),
    .partial        (partial)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch, input logic [15:0] v);
    adc[ch] = v;
    vld = 4'(1 << ch);
    mstage[ch] = v;
    step(1);
    vld = 0;
  endtask

  task automatic push_exp(input logic [3:0] v, input logic p);
    frame_t f;
    cnt_model = cnt_model + 32'd1;
    f.ch = mstage;
    f.v = v;
    f.p = p;
    f.cnt = cnt_model;
    exp_q.push_back(f);
  endtask

  task automatic full_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    pulse(0, a);
    pulse(1, b);
    pulse(2, c);
    pulse(3, d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (mon_on && sample_cnt != prev_cnt) begin
        prev_cnt = sample_cnt;
        if (exp_q.size() == 0) begin
          chk("unexp_pub", sample_cnt, cnt_model);
        end else begin
          f = exp_q.pop_front();
          chk("snap0", 32'(snap_ch0), 32'(f.ch[0]));
          chk("snap1", 32'(snap_ch1), 32'(f.ch[1]));
          chk("snap2", 32'(snap_ch2), 32'(f.ch[2]));
          chk("snap3", 32'(snap_ch3), 32'(f.ch[3]));
          chk("svalid", 32'(snap_valid), 32'(f.v));
          chk("partial", 32'(partial), 32'(f.p));
          chk("cnt", sample_cnt, f.cnt);
          chk("drdy_pub", 32'(drdy), 1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) adc[i] = 0;
    step(3);
    rst = 0;
    step(1);
    chk("rst_snap0", 32'(snap_ch0), 0);
    chk("rst_svalid", 32'(snap_valid), 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_drdy", 32'(drdy), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_part", 32'(partial), 0);
    mon_on = 1;

    // full frame, bus idle: drdy rises 3 cycles after last pulse
    enable = 1;
    step(1);
    full_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    push_exp(4'hF, 1'b0);
    step(1);
    chk("lat_n2_drdy", 32'(drdy), 0);
    step(1);
    chk("lat_n3_drdy", 32'(drdy), 1);
    chk("lat_n3_snap3", 32'(snap_ch3), 32'h4444);
    drain(10);

    // frame held while SPI transaction active
    spi_busy = 1;
    full_frame(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    push_exp(4'hF, 1'b0);
    step(10);
    chk("busy_hold0", 32'(snap_ch0), 32'h1111);
    chk("busy_cnt", sample_cnt, 1);
    chk("busy_drdy", 32'(drdy), 0);
    spi_busy = 0;
    step(1);
    chk("rel1_snap0", 32'(snap_ch0), 32'h1111);
    chk("rel1_drdy", 32'(drdy), 0);
    step(1);
    chk("rel2_snap0", 32'(snap_ch0), 32'h5555);
    chk("rel2_drdy", 32'(drdy), 1);
    chk("rel2_ovr", 32'(overrun), 0);
    drain(10);

    // unread frame overwritten -> overrun
    full_frame(16'h0009, 16'h000A, 16'h000B, 16'h000C);
    push_exp(4'hF, 1'b0);
    drain(10);
    chk("ovr_set", 32'(overrun), 1);
    clear_status = 1;
    step(1);
    clear_status = 0;
    chk("ovr_clr", 32'(overrun), 0);
    chk("drop_clr", 32'(drop_cnt), 0);

    // repeated ch0 pulses: freshest wins, two drops
    pulse(0, 16'h000A);
    pulse(0, 16'h000B);
    pulse(0, 16'h000C);
    pulse(1, 16'h0001);
    pulse(2, 16'h0002);
    pulse(3, 16'h0003);
    push_exp(4'hF, 1'b0);
    drain(10);
    chk("drop_two", 32'(drop_cnt), 2);
    clear_status = 1;
    step(1);
    clear_status = 0;
    chk("drop_clr2", 32'(drop_cnt), 0);

    // timeout publishes a partial frame
    pulse(2, 16'h0ABC);
    push_exp(4'b0100, 1'b1);
    drain(300);

    // no pulses: timeout passes silently
    step(250);
    chk("idle_to_cnt", sample_cnt, cnt_model);

    // counter wrap
    dut.sample_cnt = 32'hFFFF_FFFE;
    cnt_model = 32'hFFFF_FFFE;
    prev_cnt = 32'hFFFF_FFFE;
    full_frame(16'h1234, 16'h2345, 16'h3456, 16'h4567);
    push_exp(4'hF, 1'b0);
    drain(10);
    full_frame(16'h5678, 16'h6789, 16'h789A, 16'h89AB);
    push_exp(4'hF, 1'b0);
    drain(10);
    chk("wrap_cnt", sample_cnt, 0);

    // enable drop in COLLECT clears drdy
    enable = 0;
    step(1);
    chk("dis_drdy", 32'(drdy), 0);
    chk("dis_state", 32'(dut.state), 32'(IDLE));
    enable = 1;
    step(1);

    // enable drop in PENDING: back to IDLE, snap held, frame lost
    held0 = snap_ch0;
    spi_busy = 1;
    full_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
    step(2);
    enable = 0;
    step(1);
    chk("pend_state", 32'(dut.state), 32'(IDLE));
    chk("pend_drdy", 32'(drdy), 0);
    chk("pend_hold0", 32'(snap_ch0), 32'(held0));
    spi_busy = 0;
    enable = 1;
    step(20);
    chk("pend_cnt", sample_cnt, 0);
    chk("pend_hold0b", 32'(snap_ch0), 32'(held0));
    chk("q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
